// File: rtl/apb_mem_pkg.sv
// apb_mem_pkg: FSM state type, wait-counter width and range helper for the APB memory slave.
package apb_mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } apb_mem_state_e;

  localparam int WAIT_W = 4;

  function automatic logic in_range(input logic [63:0] idx, input int unsigned depth);
    return idx < 64'(depth);
  endfunction

endpackage

// File: rtl/apb_mem_array.sv
// apb_mem_array: DEPTH x DATA_W storage with per-byte write enables.
// Synchronous write, combinational read; no reset on contents.
module apb_mem_array #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024,
  parameter int AW     = 10
) (
  input  logic                clk,
  input  logic [DATA_W/8-1:0] we,
  input  logic [AW-1:0]       waddr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [AW-1:0]       raddr,
  output logic [DATA_W-1:0]   rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    for (int b = 0; b < DATA_W / 8; b++) begin
      if (we[b]) begin
        mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  // Non-power-of-two depths leave part of the index space unbacked.
  assign rdata = (32'(raddr) < DEPTH) ? mem[raddr] : '0;

endmodule

// File: rtl/apb_mem_slave.sv
// apb_mem_slave: APB4 memory slave with configurable width, depth, wait states and byte strobes.
// Define APB_MEM_PSLVERR_EN to add pslverr_o for out-of-range and zero-strobe-write accesses.
module apb_mem_slave
  import apb_mem_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic                pclk_i,
  input  logic                prst_i,
  input  logic [ADDR_W-1:0]   paddr_i,
  input  logic                psel_i,
  input  logic                penable_i,
  input  logic                pwrite_i,
  input  logic [DATA_W-1:0]   pwdata_i,
  input  logic [DATA_W/8-1:0] pstrb_i,
  output logic [DATA_W-1:0]   prdata_o,
  output logic                pready_o
`ifdef APB_MEM_PSLVERR_EN
  ,
  output logic                pslverr_o
`endif
);

  localparam int STRB_W = DATA_W / 8;
  localparam int OFF    = $clog2(STRB_W);
  localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  apb_mem_state_e    state;
  logic [WAIT_W-1:0] cnt;
  logic [ADDR_W-1:0] cap_addr;
  logic              cap_write;
  logic [DATA_W-1:0] cap_wdata;
  logic [STRB_W-1:0] cap_strb;
  logic [ADDR_W-1:0] idx;
  logic              hit;
  logic              complete;
  logic [STRB_W-1:0] we;
  logic [DATA_W-1:0] arr_rdata;

  assign idx = cap_addr >> OFF;
  assign hit = in_range(64'(idx), DEPTH);

  // With no wait states the access phase completes on the edge that samples penable.
  assign complete = ((state == SETUP) && psel_i && penable_i && (WAIT_STATES == 0)) ||
                    ((state == ACCESS) && psel_i && (cnt == '0));

  assign we = (complete && !prst_i && cap_write && hit) ? cap_strb : '0;

  apb_mem_array #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk  (pclk_i),
    .we   (we),
    .waddr(idx[AW-1:0]),
    .wdata(cap_wdata),
    .raddr(idx[AW-1:0]),
    .rdata(arr_rdata)
  );

  always_ff @(posedge pclk_i) begin
    if (state == IDLE && psel_i && !penable_i) begin
      cap_addr  <= paddr_i;
      cap_write <= pwrite_i;
      cap_wdata <= pwdata_i;
      cap_strb  <= pstrb_i;
    end
  end

  always_ff @(posedge pclk_i) begin
    if (prst_i) begin
      state     <= IDLE;
      cnt       <= '0;
      pready_o  <= 1'b0;
      prdata_o  <= '0;
`ifdef APB_MEM_PSLVERR_EN
      pslverr_o <= 1'b0;
`endif
    end else begin
      pready_o  <= complete;
      prdata_o  <= (complete && !cap_write && hit) ? arr_rdata : '0;
`ifdef APB_MEM_PSLVERR_EN
      pslverr_o <= complete && (!hit || (cap_write && (cap_strb == '0)));
`endif
      case (state)
        IDLE: begin
          if (psel_i && !penable_i) begin
            state <= SETUP;
          end
        end
        SETUP: begin
          if (!psel_i) begin
            state <= IDLE;
          end else if (penable_i) begin
            if (WAIT_STATES == 0) begin
              state <= IDLE;
            end else begin
              state <= ACCESS;
              // Loaded one short: the completing edge itself counts as the last wait.
              cnt   <= WAIT_W'(WAIT_STATES - 1);
            end
          end
        end
        ACCESS: begin
          if (!psel_i || cnt == '0) begin
            state <= IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_mem_slave.sv
// tb_apb_mem_slave: two slaves (0 and 3 wait states, 16 words) driven with directed and random APB traffic.
module tb_apb_mem_slave;

  localparam int DEP = 16;
  localparam int WS0 = 0;
  localparam int WS1 = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst     [2];
  logic [31:0] paddr   [2];
  logic        psel    [2];
  logic        penable [2];
  logic        pwrite  [2];
  logic [31:0] pwdata  [2];
  logic [3:0]  pstrb   [2];
  logic [31:0] prdata  [2];
  logic        pready  [2];
`ifdef APB_MEM_PSLVERR_EN
  logic        pslverr [2];
`endif

  apb_mem_slave #(.DATA_W(32), .ADDR_W(32), .DEPTH(DEP), .WAIT_STATES(WS0)) u_dut0 (
    .pclk_i(clk), .prst_i(rst[0]), .paddr_i(paddr[0]), .psel_i(psel[0]),
    .penable_i(penable[0]), .pwrite_i(pwrite[0]), .pwdata_i(pwdata[0]),
    .pstrb_i(pstrb[0]), .prdata_o(prdata[0]), .pready_o(pready[0])
`ifdef APB_MEM_PSLVERR_EN
    , .pslverr_o(pslverr[0])
`endif
  );

  apb_mem_slave #(.DATA_W(32), .ADDR_W(32), .DEPTH(DEP), .WAIT_STATES(WS1)) u_dut1 (
    .pclk_i(clk), .prst_i(rst[1]), .paddr_i(paddr[1]), .psel_i(psel[1]),
    .penable_i(penable[1]), .pwrite_i(pwrite[1]), .pwdata_i(pwdata[1]),
    .pstrb_i(pstrb[1]), .prdata_o(prdata[1]), .pready_o(pready[1])
`ifdef APB_MEM_PSLVERR_EN
    , .pslverr_o(pslverr[1])
`endif
  );

  typedef struct {
    int          d;
    logic [31:0] data;
    bit          err;
  } exp_t;

  exp_t        sbq [$];
  logic [31:0] mdl [2][DEP];
  int          checks = 0;
  int          failures = 0;
  bit          chained [2];
  int          last_setup [2];
  bit          prev_rdy [2];

  function automatic int ws(int d);
    return (d == 0) ? WS0 : WS1;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: every ready cycle consumes one scoreboard entry; other cycles must show zero data.
  always @(negedge clk) begin
    exp_t e;
    for (int d = 0; d < 2; d++) begin
      if (rst[d] !== 1'b1) begin
        if (pready[d] === 1'b1) begin
          chk("ready_one_cycle", {31'b0, prev_rdy[d]}, 32'd0);
          checks++;
          if (sbq.size() == 0) begin
            failures++;
            $display("FAIL unexpected_ready dut%0d: pready=1 with no transfer outstanding, required 0", d);
          end else begin
            e = sbq.pop_front();
            chk("sb_dut", d, e.d);
            chk("prdata", prdata[d], e.data);
`ifdef APB_MEM_PSLVERR_EN
            chk("pslverr", {31'b0, pslverr[d]}, {31'b0, e.err});
`endif
          end
        end else begin
          chk("prdata_idle", prdata[d], 32'd0);
`ifdef APB_MEM_PSLVERR_EN
          chk("pslverr_idle", {31'b0, pslverr[d]}, 32'd0);
`endif
        end
        prev_rdy[d] = (pready[d] === 1'b1);
      end else begin
        prev_rdy[d] = 1'b0;
      end
    end
  end

  task automatic bus_idle(int d, int n);
    psel[d] = 1'b0; penable[d] = 1'b0; pwrite[d] = 1'b0;
    chained[d] = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic xfer(int d, bit wr, logic [31:0] a, logic [31:0] wd, logic [3:0] st);
    exp_t e;
    int   idx;
    bit   hit;
    int   lat;
    bit   done;
    idx = int'(a >> 2);
    hit = idx < DEP;
    e.d = d;
    e.data = (!wr && hit) ? mdl[d][idx] : 32'd0;
    e.err = (!hit) || (wr && st == 4'h0);
    if (wr && hit) begin
      for (int b = 0; b < 4; b++) if (st[b]) mdl[d][idx][b*8 +: 8] = wd[b*8 +: 8];
    end
    sbq.push_back(e);
    psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr;
    paddr[d] = a; pwdata[d] = wd; pstrb[d] = st;
    @(posedge clk); #1;
    if (chained[d]) chk("b2b_period", cyc - last_setup[d], 2 + ws(d));
    last_setup[d] = cyc;
    // The slave must work from what it captured at setup, so scramble the live bus.
    penable[d] = 1'b1;
    paddr[d] = $urandom; pwdata[d] = $urandom;
    pstrb[d] = 4'($urandom); pwrite[d] = 1'($urandom);
    lat = 0; done = 1'b0;
    while (!done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (pready[d] === 1'b1) done = 1'b1;
    end
    chk("latency", lat, 1 + ws(d));
    chained[d] = done;
  endtask

  task automatic start_write(int d, logic [31:0] a, logic [31:0] wd);
    psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = 1'b1;
    paddr[d] = a; pwdata[d] = wd; pstrb[d] = 4'hF;
    @(posedge clk); #1;
    penable[d] = 1'b1;
    @(posedge clk); #1;
    chk("access_not_ready", {31'b0, pready[d]}, 32'd0);
  endtask

  task automatic abort_write(int d, logic [31:0] a, logic [31:0] wd);
    start_write(d, a, wd);
    psel[d] = 1'b0; penable[d] = 1'b0;
    repeat (ws(d) + 2) begin
      @(posedge clk); #1;
      chk("abort_no_ready", {31'b0, pready[d]}, 32'd0);
    end
    chained[d] = 1'b0;
  endtask

  task automatic reset_mid_write(int d, logic [31:0] a, logic [31:0] wd);
    start_write(d, a, wd);
    rst[d] = 1'b1;
    @(posedge clk); #1;
    chk("rst_pready", {31'b0, pready[d]}, 32'd0);
    chk("rst_prdata", prdata[d], 32'd0);
`ifdef APB_MEM_PSLVERR_EN
    chk("rst_pslverr", {31'b0, pslverr[d]}, 32'd0);
`endif
    rst[d] = 1'b0;
    bus_idle(d, 1);
  endtask

  task automatic run_dut(int d);
    for (int i = 0; i < DEP; i++) xfer(d, 1'b1, 32'(i * 4), $urandom, 4'hF);
    bus_idle(d, 1);
    xfer(d, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    xfer(d, 1'b0, 32'h10, 32'h0, 4'h0);
    bus_idle(d, 1);
    xfer(d, 1'b0, 32'h0, 32'h0, 4'h0);
    bus_idle(d, 0);
    xfer(d, 1'b1, 32'h20, 32'h11223344, 4'hF);
    xfer(d, 1'b1, 32'h20, 32'hAABBCCDD, 4'h5);
    xfer(d, 1'b0, 32'h20, 32'h0, 4'hA);
    xfer(d, 1'b1, 32'h40, 32'hCAFEF00D, 4'hF);
    xfer(d, 1'b0, 32'h40, 32'h0, 4'h0);
    xfer(d, 1'b1, 32'h24, 32'h12345678, 4'h0);
    xfer(d, 1'b0, 32'h24, 32'h0, 4'h0);
    xfer(d, 1'b0, 32'h3C, 32'h0, 4'h0);
    bus_idle(d, 1);
    if (ws(d) > 0) begin
      abort_write(d, 32'h10, 32'h55555555);
      xfer(d, 1'b0, 32'h10, 32'h0, 4'h0);
      bus_idle(d, 1);
      reset_mid_write(d, 32'h10, 32'h66666666);
      xfer(d, 1'b0, 32'h10, 32'h0, 4'h0);
      xfer(d, 1'b1, 32'h14, 32'h0BADF00D, 4'hF);
      xfer(d, 1'b0, 32'h14, 32'h0, 4'h0);
      bus_idle(d, 1);
    end
    for (int n = 0; n < 120; n++) begin
      xfer(d, 1'($urandom), 32'($urandom_range(0, 'h4F)), $urandom, 4'($urandom_range(0, 15)));
      if ($urandom_range(0, 2) == 0) bus_idle(d, $urandom_range(0, 2));
    end
    bus_idle(d, 2);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t, required completion earlier", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; psel[d] = 1'b0; penable[d] = 1'b0; pwrite[d] = 1'b0;
      paddr[d] = '0; pwdata[d] = '0; pstrb[d] = '0;
      chained[d] = 1'b0; last_setup[d] = 0; prev_rdy[d] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("reset_pready", {31'b0, pready[d]}, 32'd0);
      chk("reset_prdata", prdata[d], 32'd0);
`ifdef APB_MEM_PSLVERR_EN
      chk("reset_pslverr", {31'b0, pslverr[d]}, 32'd0);
`endif
      rst[d] = 1'b0;
    end
    @(posedge clk); #1;
    run_dut(0);
    run_dut(1);
    repeat (5) @(posedge clk);
    #1;
    chk("sb_drained", sbq.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
